fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8, instruction memory address width.
REQ-002 Parameter TIMEOUT, default 15, maximum wait cycles for mem_ready per fetch.
REQ-003 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  single system clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 run  in  1  level; 1 permits fetching, 0 holds in IDLE once the current instruction completes.
REQ-007 halt_req  in  1  single-cycle request to stop after the current instruction.
REQ-008 pc_load  in  1  jump strobe; loads pc_load_val into PC.
REQ-009 pc_load_val  in  ADDR_W  jump target.
REQ-010 mem_addr  out  ADDR_W  fetch address, equal to PC while mem_rd=1.
REQ-011 mem_rd  out  1  read request, held until mem_ready or timeout.
REQ-012 mem_ready  in  1  memory data valid this cycle.
REQ-013 mem_data  in  16  instruction word.
REQ-014 instr  out  16  instruction register driven to the control unit.
REQ-015 new_instr  out  1  one-cycle pulse: instr is freshly valid.
REQ-016 done  in  1  control unit finished executing instr.
REQ-017 pc  out  ADDR_W  current program counter.
REQ-018 busy  out  1  1 in any state other than IDLE and HALTED.
REQ-019 err  out  1  sticky fetch-timeout flag.

Function
REQ-020 States SHALL be IDLE, FETCH, ISSUE, EXEC, HALTED.
REQ-021 IDLE -> FETCH when run=1 and err=0; otherwise remain.
REQ-022 FETCH: mem_rd=1, mem_addr=pc; on mem_ready, instr<=mem_data, pc<=pc+1 (mod 2^ADDR_W), -> ISSUE.
REQ-023 FETCH timeout: after TIMEOUT consecutive cycles without mem_ready, set err=1, drop mem_rd, -> HALTED; instr and pc unchanged.
REQ-024 ISSUE: new_instr=1 for exactly one cycle, -> EXEC.
REQ-025 EXEC: wait for done; on done -> HALTED if a halt is pending, else FETCH if run=1, else IDLE.
REQ-026 done outside EXEC SHALL be ignored.
REQ-027 halt_req in any state SHALL latch a pending halt, cleared on entry to HALTED; in IDLE it SHALL go directly to HALTED.
REQ-028 HALTED: exit only by reset; mem_rd=0, new_instr=0.
REQ-029 pc_load SHALL be accepted in IDLE or EXEC only; ignored in FETCH and ISSUE.
REQ-030 pc_load coincident with done: PC takes pc_load_val and the next fetch uses it.
REQ-031 PC wrap: pc=2^ADDR_W-1 fetch yields pc=0 afterwards; no flag.
REQ-032 Fetch-to-issue latency: new_instr asserts the cycle after the mem_ready cycle.
REQ-033 instr SHALL hold its value from load until the next successful fetch.

Reset
REQ-034 On rst=0, asynchronously: state=IDLE, pc=0, instr=0, new_instr=0, mem_rd=0, err=0, busy=0, pending halt and timeout counter cleared.
REQ-035 Reset mid-FETCH SHALL drop mem_rd immediately; a mem_ready arriving during or after reset in IDLE is ignored.

Structure
REQ-036 Shared package fetch_pkg SHALL hold the state enumeration, ADDR_W and TIMEOUT defaults, and instruction width constant 16.
REQ-037 One sub-module pc_counter (ADDR_W register with increment, load, async active-low reset) SHALL hold the PC.
REQ-038 Timeout counter width SHALL be clog2(TIMEOUT+1).

Verification
REQ-039 Reset, run=1, mem_ready one cycle after mem_rd with mem_data=16'h2A5C, done 3 cycles after new_instr -> instr=16'h2A5C, pc=1, single new_instr pulse, next mem_rd at address 1.
REQ-040 pc at 8'hFF, fetch completes -> pc=8'h00, next mem_addr=8'h00.
REQ-041 mem_ready held low 15 cycles -> err=1, mem_rd=0, state HALTED; err persists until rst=0.
REQ-042 halt_req during EXEC, done 2 cycles later -> HALTED after done, no further mem_rd.
REQ-043 pc_load=1, pc_load_val=8'h40 in same cycle as done -> next mem_addr=8'h40.
REQ-044 rst=0 asserted mid-FETCH -> mem_rd drops without a clock edge; after release with run=0, stays IDLE, pc=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and size defaults for the fetch sequencer.
package fetch_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int TIMEOUT_DEF = 15;
  localparam int INSTR_W = 16;
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, EXEC, HALTED} state_t;
endpackage

// File: rtl/pc_counter.sv
// pc_counter: program counter with jump load and wrapping increment.
import fetch_pkg::*;
module pc_counter #(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] pc
);
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) pc <= '0;
    else if (load) pc <= load_val;
    else if (inc) pc <= pc + ONE;
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetches instructions from memory, issues them and waits for execution.
import fetch_pkg::*;
module fetch_sequencer #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               halt_req,
  input  logic               pc_load,
  input  logic [ADDR_W-1:0]  pc_load_val,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rd,
  input  logic               mem_ready,
  input  logic [INSTR_W-1:0] mem_data,
  output logic [INSTR_W-1:0] instr,
  output logic               new_instr,
  input  logic               done,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] ONE = CW'(1);
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic halt_pend, halt_any, got, tout;
  assign halt_any = halt_pend | halt_req;
  assign got = (state == FETCH) & mem_ready;
  assign tout = (state == FETCH) & ~mem_ready & (cnt == LAST);
  assign mem_rd = state == FETCH;
  assign mem_addr = pc;
  assign new_instr = state == ISSUE;
  assign busy = (state != IDLE) & (state != HALTED);
  pc_counter #(.ADDR_W(ADDR_W)) u_pc (
    .clk(clk),
    .rst(rst),
    .inc(got),
    .load(pc_load & ((state == IDLE) | (state == EXEC))),
    .load_val(pc_load_val),
    .pc(pc)
  );
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = halt_any ? HALTED : (run & ~err) ? FETCH : IDLE;
      FETCH:   nxt = mem_ready ? ISSUE : tout ? HALTED : FETCH;
      ISSUE:   nxt = EXEC;
      EXEC:    nxt = ~done ? EXEC : halt_any ? HALTED : run ? FETCH : IDLE;
      default: nxt = HALTED;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      halt_pend <= 1'b0;
      err <= 1'b0;
      instr <= '0;
    end else begin
      state <= nxt;
      cnt <= ((state == FETCH) & ~mem_ready) ? cnt + ONE : '0;
      halt_pend <= (nxt == HALTED) ? 1'b0 : halt_any;
      err <= err | tout;
      if (got) instr <= mem_data;
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed checks of fetch, wrap, timeout, halt, jump and reset behaviour.
module tb_fetch_sequencer;
  logic clk = 0, rst = 0, run = 0, halt_req = 0, pc_load = 0, mem_ready = 0, done = 0;
  logic [7:0] pc_load_val = 0;
  logic [15:0] mem_data = 0;
  logic [7:0] mem_addr, pc;
  logic [15:0] instr;
  logic mem_rd, new_instr, busy, err;
  int checks = 0, failures = 0;

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .run(run), .halt_req(halt_req), .pc_load(pc_load),
    .pc_load_val(pc_load_val), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_ready(mem_ready), .mem_data(mem_data), .instr(instr),
    .new_instr(new_instr), .done(done), .pc(pc), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0;
    {run, halt_req, pc_load, mem_ready, done} = '0;
    pc_load_val = 0;
    mem_data = 0;
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({mem_rd, new_instr, busy, err} !== 4'b0 || pc !== 8'h00 || instr !== 16'h0) begin
      failures++;
      $display("FAIL reset: rd/ni/busy/err=%b pc=%h instr=%h, want 0000 00 0000", {mem_rd, new_instr, busy, err}, pc, instr);
    end
  endtask

  task automatic test_basic_fetch();
    int pulses = 0;
    do_reset();
    run = 1;
    tick();
    checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 8'h00 || busy !== 1'b1) begin
      failures++;
      $display("FAIL fetch_start: rd=%b addr=%h busy=%b, want 1 00 1", mem_rd, mem_addr, busy);
    end
    tick();
    mem_ready = 1;
    mem_data = 16'h2A5C;
    pulses += int'(new_instr);
    tick();
    mem_ready = 0;
    mem_data = 16'hFFFF;
    pulses += int'(new_instr);
    checks++;
    if (instr !== 16'h2A5C || pc !== 8'h01 || new_instr !== 1'b1 || mem_rd !== 1'b0) begin
      failures++;
      $display("FAIL issue: instr=%h pc=%h ni=%b rd=%b, want 2a5c 01 1 0", instr, pc, new_instr, mem_rd);
    end
    repeat (3) begin
      tick();
      pulses += int'(new_instr);
    end
    done = 1;
    tick();
    done = 0;
    checks++;
    if (pulses !== 1) begin
      failures++;
      $display("FAIL new_instr_pulses: got %0d, want 1", pulses);
    end
    checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 8'h01 || instr !== 16'h2A5C) begin
      failures++;
      $display("FAIL next_fetch: rd=%b addr=%h instr=%h, want 1 01 2a5c", mem_rd, mem_addr, instr);
    end
    done = 1;
    pc_load = 1;
    pc_load_val = 8'h77;
    tick();
    tick();
    done = 0;
    pc_load = 0;
    checks++;
    if (mem_rd !== 1'b1 || pc !== 8'h01 || new_instr !== 1'b0) begin
      failures++;
      $display("FAIL ignore_in_fetch: rd=%b pc=%h ni=%b, want 1 01 0", mem_rd, pc, new_instr);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    pc_load = 1;
    pc_load_val = 8'hFF;
    tick();
    pc_load = 0;
    checks++;
    if (pc !== 8'hFF || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_load: pc=%h busy=%b, want ff 0", pc, busy);
    end
    run = 1;
    tick();
    checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 8'hFF) begin
      failures++;
      $display("FAIL wrap_addr: rd=%b addr=%h, want 1 ff", mem_rd, mem_addr);
    end
    mem_ready = 1;
    mem_data = 16'hBEEF;
    tick();
    mem_ready = 0;
    checks++;
    if (pc !== 8'h00 || instr !== 16'hBEEF || err !== 1'b0) begin
      failures++;
      $display("FAIL wrap_pc: pc=%h instr=%h err=%b, want 00 beef 0", pc, instr, err);
    end
    tick();
    done = 1;
    tick();
    done = 0;
    checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 8'h00) begin
      failures++;
      $display("FAIL wrap_next: rd=%b addr=%h, want 1 00", mem_rd, mem_addr);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    run = 1;
    tick();
    mem_ready = 1;
    mem_data = 16'h1234;
    tick();
    mem_ready = 0;
    tick();
    done = 1;
    tick();
    done = 0;
    repeat (14) tick();
    checks++;
    if (mem_rd !== 1'b1 || err !== 1'b0) begin
      failures++;
      $display("FAIL pre_timeout: rd=%b err=%b, want 1 0", mem_rd, err);
    end
    tick();
    checks++;
    if (err !== 1'b1 || mem_rd !== 1'b0 || busy !== 1'b0 || instr !== 16'h1234 || pc !== 8'h01) begin
      failures++;
      $display("FAIL timeout: err=%b rd=%b busy=%b instr=%h pc=%h, want 1 0 0 1234 01", err, mem_rd, busy, instr, pc);
    end
    mem_ready = 1;
    done = 1;
    repeat (5) tick();
    mem_ready = 0;
    done = 0;
    checks++;
    if (err !== 1'b1 || mem_rd !== 1'b0 || new_instr !== 1'b0 || instr !== 16'h1234) begin
      failures++;
      $display("FAIL timeout_sticky: err=%b rd=%b ni=%b instr=%h, want 1 0 0 1234", err, mem_rd, new_instr, instr);
    end
    do_reset();
    #1;
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL err_clear: err=%b, want 0", err);
    end
  endtask

  task automatic test_halt();
    int rds = 0;
    do_reset();
    run = 1;
    tick();
    mem_ready = 1;
    tick();
    mem_ready = 0;
    tick();
    halt_req = 1;
    tick();
    halt_req = 0;
    tick();
    done = 1;
    tick();
    done = 0;
    checks++;
    if (busy !== 1'b0 || mem_rd !== 1'b0) begin
      failures++;
      $display("FAIL halt_after_done: busy=%b rd=%b, want 0 0", busy, mem_rd);
    end
    repeat (6) begin
      done = ~done;
      tick();
      rds += int'(mem_rd) + int'(new_instr);
    end
    done = 0;
    checks++;
    if (rds !== 0) begin
      failures++;
      $display("FAIL halted_quiet: rd+ni cycles=%0d, want 0", rds);
    end
    do_reset();
    halt_req = 1;
    tick();
    halt_req = 0;
    run = 1;
    tick();
    tick();
    checks++;
    if (mem_rd !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_halt: rd=%b busy=%b, want 0 0", mem_rd, busy);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    run = 1;
    tick();
    mem_ready = 1;
    mem_data = 16'h0101;
    tick();
    mem_ready = 0;
    tick();
    pc_load = 1;
    pc_load_val = 8'h40;
    done = 1;
    tick();
    pc_load = 0;
    done = 0;
    checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 8'h40) begin
      failures++;
      $display("FAIL jump_on_done: rd=%b addr=%h, want 1 40", mem_rd, mem_addr);
    end
    mem_ready = 1;
    mem_data = 16'h0202;
    tick();
    mem_ready = 0;
    checks++;
    if (instr !== 16'h0202 || pc !== 8'h41 || new_instr !== 1'b1) begin
      failures++;
      $display("FAIL second_fetch: instr=%h pc=%h ni=%b, want 0202 41 1", instr, pc, new_instr);
    end
    run = 0;
    tick();
    done = 1;
    tick();
    done = 0;
    checks++;
    if (busy !== 1'b0 || mem_rd !== 1'b0 || instr !== 16'h0202) begin
      failures++;
      $display("FAIL run_low_idle: busy=%b rd=%b instr=%h, want 0 0 0202", busy, mem_rd, instr);
    end
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    run = 1;
    tick();
    tick();
    #2;
    rst = 0;
    mem_ready = 1;
    run = 0;
    #1;
    checks++;
    if (mem_rd !== 1'b0 || pc !== 8'h00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: rd=%b pc=%h busy=%b, want 0 00 0", mem_rd, pc, busy);
    end
    tick();
    @(negedge clk);
    rst = 1;
    repeat (3) tick();
    mem_ready = 0;
    checks++;
    if (mem_rd !== 1'b0 || busy !== 1'b0 || pc !== 8'h00 || instr !== 16'h0 || new_instr !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle: rd=%b busy=%b pc=%h instr=%h ni=%b, want 0 0 00 0000 0", mem_rd, busy, pc, instr, new_instr);
    end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_wrap();
    test_timeout();
    test_halt();
    test_back_to_back();
    test_reset_mid_fetch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
